// File: rtl/count_pkg.sv
// Shared constants, types and the step classifier for the count sampler.
package count_pkg;

  localparam int   CNT_W       = 4;
  localparam logic DIR_UP      = 1'b1;
  localparam logic DIR_DOWN    = 1'b0;
  localparam int   SYNC_STAGES = 2;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    cnt_t count;
    logic dir;
    logic err;
  } evt_t;

  // A single step either way is clean; any other nonzero delta is a jump whose
  // direction is taken from the shorter way round the ring.
  function automatic evt_t classify(cnt_t new_val, cnt_t old_val);
    evt_t e;
    cnt_t delta;
    delta   = new_val - old_val;
    e.count = new_val;
    if (delta == cnt_t'(1)) begin
      e.dir = DIR_UP;
      e.err = 1'b0;
    end else if (delta == '1) begin
      e.dir = DIR_DOWN;
      e.err = 1'b0;
    end else begin
      e.dir = ~delta[CNT_W-1];
      e.err = 1'b1;
    end
    return e;
  endfunction

endpackage

// File: rtl/count_sampler_if.sv
// Output event handshake: the sampler is master, the consumer is slave.
interface count_sampler_if;
  import count_pkg::*;

  logic out_valid;
  logic out_ready;
  cnt_t out_count;
  logic out_dir;
  logic out_err;

  modport master (output out_valid, out_count, out_dir, out_err, input out_ready);
  modport slave  (input out_valid, out_count, out_dir, out_err, output out_ready);

endinterface

// File: rtl/sync2.sv
// Single-bit multi-flop synchronizer for a signal asynchronous to clk.
module sync2
  import count_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stage_q;
  logic [SYNC_STAGES-1:0] stage_d;

  always_comb stage_d = {stage_q[SYNC_STAGES-2:0], d};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stage_q <= '0;
    else     stage_q <= stage_d;
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/count_sampler.sv
// Samples an asynchronous ripple counter, accepts only settled values and
// reports each change as a classified event with wrap counting.
module count_sampler
  import count_pkg::*;
#(
  parameter int STABLE_CYCLES = 2,
  parameter int WRAP_W        = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CNT_W-1:0]      cnt_in,
  count_sampler_if.master       out_if,
  output logic                  wrap_pulse,
  output logic [WRAP_W-1:0]     wrap_cnt,
  output logic                  overrun
);

  localparam logic [2:0] STAB_MAX = 3'(STABLE_CYCLES);

  cnt_t              s2;
  cnt_t              s3_q, s3_d;
  logic [2:0]        stab_q, stab_d;
  cnt_t              acc_q, acc_d;
  evt_t              out_q, out_d;
  logic              valid_q, valid_d;
  logic              pulse_q, pulse_d;
  logic [WRAP_W-1:0] wrap_q, wrap_d;
  logic              ovr_q, ovr_d;
  logic              fire;
  logic              is_wrap;
  evt_t              evt;

  for (genvar gi = 0; gi < CNT_W; gi++) begin : g_sync
    sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .d   (cnt_in[gi]),
      .q   (s2[gi])
    );
  end

  always_comb begin
    s3_d   = s2;
    stab_d = (s2 != s3_q) ? 3'd0
           : (stab_q == STAB_MAX) ? stab_q : stab_q + 3'd1;
    // The s2 == s3 term keeps a saturated counter from accepting the first
    // sample of a new value before it has been seen twice.
    fire    = (stab_q == STAB_MAX) && (s2 == s3_q) && (s2 != acc_q);
    evt     = classify(s2, acc_q);
    is_wrap = !evt.err && (((acc_q == '1) && (s2 == '0)) ||
                           ((acc_q == '0) && (s2 == '1)));

    acc_d   = acc_q;
    out_d   = out_q;
    valid_d = valid_q;
    pulse_d = 1'b0;
    wrap_d  = wrap_q;
    ovr_d   = ovr_q;

    if (fire) begin
      acc_d   = s2;
      out_d   = evt;
      valid_d = 1'b1;
      if (valid_q && !out_if.out_ready) ovr_d = 1'b1;
      if (is_wrap) begin
        pulse_d = 1'b1;
        if (wrap_q != '1) wrap_d = wrap_q + WRAP_W'(1);
      end
    end else if (valid_q && out_if.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_q    <= '0;
      stab_q  <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      pulse_q <= 1'b0;
      wrap_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      s3_q    <= s3_d;
      stab_q  <= stab_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      pulse_q <= pulse_d;
      wrap_q  <= wrap_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_if.out_valid = valid_q;
  assign out_if.out_count = out_q.count;
  assign out_if.out_dir   = out_q.dir;
  assign out_if.out_err   = out_q.err;
  assign wrap_pulse       = pulse_q;
  assign wrap_cnt         = wrap_q;
  assign overrun          = ovr_q;

endmodule

// File: tb/tb_count_sampler.sv
// Bench for count_sampler: directed table, corner-case sequences and random
// stimulus against a sample-history reference model.
module tb_count_sampler;

  localparam int S  = 2;
  localparam int WW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    cnt_in;
  logic          wrap_pulse;
  logic [WW-1:0] wrap_cnt;
  logic          overrun;

  count_sampler_if bus ();

  count_sampler #(.STABLE_CYCLES(S), .WRAP_W(WW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cnt_in     (cnt_in),
    .out_if     (bus),
    .wrap_pulse (wrap_pulse),
    .wrap_cnt   (wrap_cnt),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: an event fires once S+2 consecutive clock samples of
  // cnt_in agree (the newest two are still inside the synchronizer).
  int         hist[$];
  logic [3:0] m_acc, m_count;
  logic       m_valid, m_dir, m_err, m_pulse, m_ovr;
  logic [1:0] m_wrap;

  task automatic model_reset();
    hist = {};
    for (int i = 0; i < S + 4; i++) hist.push_back(0);
    m_acc = 0; m_count = 0; m_valid = 0; m_dir = 0; m_err = 0;
    m_pulse = 0; m_ovr = 0; m_wrap = 0;
  endtask

  task automatic model_edge(input int c, input logic rdy);
    int n, v, delta;
    bit fire, err, dir;
    hist.push_back(c);
    if (hist.size() > S + 4) hist.delete(0);
    n    = hist.size();
    v    = hist[n-3];
    fire = (v != int'(m_acc));
    for (int i = 0; i < S + 2; i++)
      if (hist[n-3-i] != v) fire = 0;
    m_pulse = 0;
    if (fire) begin
      delta = (v - int'(m_acc)) & 15;
      err   = !(delta == 1 || delta == 15);
      dir   = (delta == 1) ? 1 : (delta == 15) ? 0 : (delta < 8);
      if (!err && ((m_acc == 15 && v == 0) || (m_acc == 0 && v == 15))) begin
        m_pulse = 1;
        if (m_wrap != 2'b11) m_wrap = m_wrap + 2'd1;
      end
      if (m_valid && !rdy) m_ovr = 1;
      m_valid = 1;
      m_count = 4'(v);
      m_dir   = dir;
      m_err   = err;
      m_acc   = 4'(v);
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
  endtask

  function automatic logic [15:0] dut_vec();
    return {5'b0, bus.out_valid, bus.out_count, bus.out_dir, bus.out_err,
            wrap_pulse, wrap_cnt, overrun};
  endfunction

  function automatic logic [15:0] model_vec();
    return {5'b0, m_valid, m_count, m_dir, m_err, m_pulse, m_wrap, m_ovr};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(int'(cnt_in), bus.out_ready);
    #1;
    check("model", dut_vec(), model_vec());
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_async_clear", dut_vec(), 16'h0);
    model_reset();
    repeat (2) step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0] cnt;
    logic       rdy;
    int         hold;
    logic       valid;
    logic [3:0] count;
    logic       dir;
    logic       err;
    logic [1:0] wrap;
    logic       ovr;
  } vec_t;

  vec_t       tbl[12];
  bit         seen;
  logic [3:0] cur;

  initial begin
    tbl[0]  = '{4'd1,  1'b1, 10, 1'b0, 4'd1,  1'b1, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{4'd2,  1'b1, 10, 1'b0, 4'd2,  1'b1, 1'b0, 2'd0, 1'b0};
    tbl[2]  = '{4'd15, 1'b1, 10, 1'b0, 4'd15, 1'b0, 1'b1, 2'd0, 1'b0};
    tbl[3]  = '{4'd0,  1'b1, 10, 1'b0, 4'd0,  1'b1, 1'b0, 2'd1, 1'b0};
    tbl[4]  = '{4'd15, 1'b1, 10, 1'b0, 4'd15, 1'b0, 1'b0, 2'd2, 1'b0};
    tbl[5]  = '{4'd0,  1'b1, 10, 1'b0, 4'd0,  1'b1, 1'b0, 2'd3, 1'b0};
    tbl[6]  = '{4'd15, 1'b1, 10, 1'b0, 4'd15, 1'b0, 1'b0, 2'd3, 1'b0};
    tbl[7]  = '{4'd5,  1'b1, 10, 1'b0, 4'd5,  1'b1, 1'b1, 2'd3, 1'b0};
    tbl[8]  = '{4'd4,  1'b1, 10, 1'b0, 4'd4,  1'b0, 1'b0, 2'd3, 1'b0};
    tbl[9]  = '{4'd5,  1'b0, 10, 1'b1, 4'd5,  1'b1, 1'b0, 2'd3, 1'b0};
    tbl[10] = '{4'd6,  1'b0, 10, 1'b1, 4'd6,  1'b1, 1'b0, 2'd3, 1'b1};
    tbl[11] = '{4'd6,  1'b1, 1,  1'b0, 4'd6,  1'b1, 1'b0, 2'd3, 1'b1};

    rst = 1'b1;
    cnt_in = 4'd0;
    bus.out_ready = 1'b1;
    model_reset();
    repeat (2) step();
    check("reset_state", dut_vec(), 16'h0);
    rst = 1'b0;

    // Directed table
    for (int r = 0; r < 12; r++) begin
      cnt_in = tbl[r].cnt;
      bus.out_ready = tbl[r].rdy;
      repeat (tbl[r].hold) step();
      check("tbl_row",
            {6'b0, bus.out_valid, bus.out_count, bus.out_dir, bus.out_err, wrap_cnt, overrun},
            {6'b0, tbl[r].valid, tbl[r].count, tbl[r].dir, tbl[r].err, tbl[r].wrap, tbl[r].ovr});
      $display("[TB] row %0d cnt=%0d rdy=%0d valid=%0d count=%0d dir=%0d err=%0d wrap=%0d ovr=%0d",
               r, tbl[r].cnt, tbl[r].rdy, bus.out_valid, bus.out_count, bus.out_dir,
               bus.out_err, wrap_cnt, overrun);
    end

    // Latency: valid appears after the sixth edge
    bus.out_ready = 1'b1;
    cnt_in = 4'd0;
    pulse_reset();
    cnt_in = 4'd1;
    repeat (5) step();
    check("lat_pre", {15'b0, bus.out_valid}, 16'h0);
    step();
    check("lat_edge6", {11'b0, bus.out_valid, bus.out_count}, {11'b0, 1'b1, 4'd1});
    $display("[TB] latency 0->1 valid=%0d count=%0d", bus.out_valid, bus.out_count);

    // Wrap strobe lasts exactly the cycle after the event edge
    cnt_in = 4'd15;
    repeat (10) step();
    cnt_in = 4'd0;
    repeat (5) step();
    check("wrap_pulse_pre", {15'b0, wrap_pulse}, 16'h0);
    step();
    check("wrap_pulse_on", {15'b0, wrap_pulse}, 16'h1);
    step();
    check("wrap_pulse_off", {15'b0, wrap_pulse}, 16'h0);
    $display("[TB] wrap 15->0 wrap_cnt=%0d", wrap_cnt);

    // Glitch then jump
    cnt_in = 4'd0;
    pulse_reset();
    cnt_in = 4'd3;
    step();
    cnt_in = 4'd0;
    seen = 0;
    repeat (12) begin
      step();
      if (bus.out_valid) seen = 1;
    end
    check("glitch_no_event", {15'b0, seen}, 16'h0);
    cnt_in = 4'd5;
    repeat (10) step();
    check("jump_0_5", {9'b0, bus.out_count, bus.out_dir, bus.out_err, wrap_cnt},
          {9'b0, 4'd5, 1'b1, 1'b1, 2'd0});
    $display("[TB] glitch 3 then jump 5 count=%0d err=%0d", bus.out_count, bus.out_err);

    // Reset mid-operation discards the pending event
    cnt_in = 4'd0;
    pulse_reset();
    cnt_in = 4'd7;
    repeat (2) step();
    pulse_reset();
    repeat (5) step();
    check("rst_lat_pre", {15'b0, bus.out_valid}, 16'h0);
    step();
    check("rst_event", {9'b0, bus.out_valid, bus.out_count, bus.out_dir, bus.out_err},
          {9'b0, 1'b1, 4'd7, 1'b1, 1'b1});
    $display("[TB] reset mid-op then 7 count=%0d err=%0d", bus.out_count, bus.out_err);

    // Zero held across reset release
    cnt_in = 4'd0;
    pulse_reset();
    seen = 0;
    repeat (12) begin
      step();
      if (bus.out_valid) seen = 1;
    end
    check("zero_across_reset", {15'b0, seen}, 16'h0);
    $display("[TB] zero across reset valid_seen=%0d", seen);

    // Random segments
    pulse_reset();
    cur = 4'd0;
    for (int seg = 0; seg < 200; seg++) begin
      int r, hold;
      r = $urandom_range(0, 3);
      if (r == 0)      cur = cur + 4'd1;
      else if (r == 1) cur = cur - 4'd1;
      else             cur = 4'($urandom_range(0, 15));
      hold = $urandom_range(1, 8);
      cnt_in = cur;
      for (int h = 0; h < hold; h++) begin
        bus.out_ready = 1'($urandom_range(0, 1));
        step();
      end
      if ($urandom_range(0, 39) == 0) pulse_reset();
      $display("[TB] rand seg %0d cnt=%0d hold=%0d valid=%0d count=%0d wrap=%0d ovr=%0d",
               seg, cur, hold, bus.out_valid, bus.out_count, wrap_cnt, overrun);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/count_sampler.md
COUNT_SAMPLER -- requirements
Module: count_sampler

Interface
REQ-001 Parameter STABLE_CYCLES, default 2, consecutive matching synchronized samples required before a count value is accepted (legal 1..7).
REQ-002 Parameter WRAP_W, default 8, width of the wrap counter.
REQ-003 clk  input  1  system clock; all state is on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cnt_in  input  4  ripple up/down counter value, asynchronous to clk, may glitch between settled values.
REQ-006 out_ready  input  1  consumer accepts out_count when high with out_valid.
REQ-007 out_valid  output  1  out_count/out_dir/out_err hold an unconsumed event.
REQ-008 out_count  output  4  accepted stable count value.
REQ-009 out_dir  output  1  step direction of the event: 1 = up, 0 = down.
REQ-010 out_err  output  1  event was a jump (delta not +1 or -1 mod 16).
REQ-011 wrap_pulse  output  1  one-cycle strobe on a wrap event.
REQ-012 wrap_cnt  output  WRAP_W  number of wraps since reset, saturating.
REQ-013 overrun  output  1  sticky: an event replaced an unconsumed event.

Function
REQ-014 Each cnt_in bit SHALL pass a two-flop synchronizer; result s2; s2 registered once more into s3.
REQ-015 stab_cnt SHALL clear when s2 != s3, else increment, saturating at STABLE_CYCLES.
REQ-016 An event SHALL fire in a cycle where stab_cnt == STABLE_CYCLES and s2 != acc_val; acc_val loads s2 on that edge.
REQ-017 Latency: cnt_in settling before an edge SHALL produce out_valid high after the (4 + STABLE_CYCLES)th rising edge.
REQ-018 A value stable for fewer than STABLE_CYCLES matching samples SHALL produce no event and leave acc_val unchanged.
REQ-019 Classification, delta = (s2 - acc_val) mod 16: 1 -> dir=1 err=0; 15 -> dir=0 err=0; other nonzero -> err=1, dir = (delta < 8).
REQ-020 Wrap: acc_val 15 -> s2 0 (delta 1) or acc_val 0 -> s2 15 (delta 15) SHALL assert wrap_pulse for exactly the cycle following the event edge and increment wrap_cnt, saturating at all-ones.
REQ-021 Jump events (err=1) SHALL never count as wraps.
REQ-022 Output register loads on an event edge; out_valid sets; out_valid clears on an edge with out_valid && out_ready and no event.
REQ-023 Event on the same edge as out_valid && out_ready SHALL load new data, keep out_valid high, no overrun.
REQ-024 Event while out_valid && !out_ready SHALL overwrite output data and set overrun; overrun clears only on reset.
REQ-025 out_count/out_dir/out_err SHALL stay constant while out_valid && !out_ready absent an event.

Reset
REQ-026 rst SHALL asynchronously clear synchronizer flops, s3, stab_cnt, acc_val (0), out_valid, out_count, out_dir, out_err, wrap_pulse, wrap_cnt, overrun.
REQ-027 Reset mid-operation SHALL discard any pending event; first post-reset event requires full REQ-017 latency from a nonzero settled cnt_in.
REQ-028 cnt_in = 0 held across reset release SHALL produce no event.

Structure
REQ-029 Shared package count_pkg SHALL hold CNT_W = 4, DIR_UP = 1, DIR_DOWN = 0 and the 2-flop sync depth constant.
REQ-030 One sub-module sync2 (single-bit two-flop synchronizer, clk/rst/d/q), instantiated CNT_W times.
REQ-031 Total RTL 120-400 lines, no combinational path from cnt_in to any output.

Verification
REQ-032 Up sequence: cnt_in 0->1->2, each held 10 clk, out_ready=1 -> two events, out_count 1 then 2, out_dir=1, out_err=0, valid at edge 6 after each change.
REQ-033 Wrap both ways: 15->0 then 0->15, held 10 clk -> two wrap_pulse strobes, wrap_cnt=2, out_dir 1 then 0.
REQ-034 Glitch: cnt_in 3 for 1 clk then back to 0 -> no out_valid, acc_val remains 0; jump 0->5 -> out_err=1, out_dir=1, wrap_cnt unchanged.
REQ-035 Backpressure: out_ready=0, steps 0->1->2 -> out_count=2, overrun=1; then out_ready=1 -> out_valid drops next edge, overrun stays 1.
REQ-036 Saturation: WRAP_W=2, four up wraps -> wrap_cnt=3 after the third and fourth.
REQ-037 Reset mid-operation: assert rst 2 clk after cnt_in 0->7 -> no event, all outputs 0; after release cnt_in=7 -> event out_count=7, out_err=1.
